ate_tile_scheduler: RTL

- Sequences the adaptive-threshold datapath for one frame.
- Walks a raster-stored frame in 8x8 tile order and issues frame-memory read addresses.
- Delivers pixels downstream over a valid/ready stream, with tile markers and an edge-column flag for each tile.
- Sits between the frame memory and the threshold engine; driven by a start/done pair from the top-level controller.

---
 rtl/ate_tile_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ate_tile_scheduler.sv
// Tile-order frame scanner: walks a raster frame in 8x8 tiles, reads frame memory and streams pixels with tile sideband.
// Optional build macro ATE_SCHED_SKIP_EDGE_EN drops the first and last tile columns from the scan.
module ate_tile_scheduler #(
  parameter int TILES_X = 6,
  parameter int TILES_Y = 4,
  parameter int ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_data,
  output logic              tile_first,
  output logic              tile_last,
  output logic              tile_edge,
  output logic [7:0]        tile_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic       first;
    logic       last;
    logic       edg;
    logic [7:0] idx;
  } sb_t;

  typedef struct packed {
    logic [7:0] data;
    sb_t        sb;
  } ent_t;

`ifdef ATE_SCHED_SKIP_EDGE_EN
  localparam int TX_LO = 1;
  localparam int TX_HI = TILES_X - 2;
`else
  localparam int TX_LO = 0;
  localparam int TX_HI = TILES_X - 1;
`endif

  state_t     r_state;
  logic [2:0] r_px;
  logic [2:0] r_py;
  logic [7:0] r_tx;
  logic [7:0] r_ty;

  logic       r_vld_p1;
  sb_t        r_sb_p1;

  ent_t       r_fifo [2];
  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_cnt;

  logic       w_pop;
  logic       w_final;
  logic [2:0] w_used;
  sb_t        w_sb;
  ent_t       w_head;

  // Credits: buffered + in-flight, minus the entry leaving this cycle, must stay below 2.
  assign w_pop   = (r_cnt != 2'd0) && pix_ready;
  assign w_used  = 3'(r_cnt) + 3'(r_vld_p1) - 3'(w_pop);
  assign mem_rd  = (r_state == S_RUN) && (w_used < 3'd2);
  assign mem_addr = (r_state == S_RUN)
                  ? ADDR_W'(((32'(r_ty) << 3) + 32'(r_py)) * 32'(TILES_X * 8)
                            + (32'(r_tx) << 3) + 32'(r_px))
                  : '0;

  assign w_final = (r_px == 3'd7) && (r_py == 3'd7) &&
                   (r_tx == 8'(TX_HI)) && (r_ty == 8'(TILES_Y - 1));

  always_comb begin
    w_sb       = '0;
    w_sb.first = (r_px == 3'd0) && (r_py == 3'd0);
    w_sb.last  = (r_px == 3'd7) && (r_py == 3'd7);
`ifdef ATE_SCHED_SKIP_EDGE_EN
    w_sb.edg   = 1'b0;
`else
    w_sb.edg   = (r_tx == 8'd0) || (r_tx == 8'(TILES_X - 1));
`endif
    w_sb.idx   = 8'(32'(r_ty) * 32'(TILES_X) + 32'(r_tx));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_px    <= 3'd0;
      r_py    <= 3'd0;
      r_tx    <= 8'(TX_LO);
      r_ty    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          r_px <= 3'd0;
          r_py <= 3'd0;
          r_tx <= 8'(TX_LO);
          r_ty <= 8'd0;
          if (start) begin
            r_state <= S_RUN;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (mem_rd) begin
            if (w_final) begin
              r_state <= S_DRAIN;
            end
            r_px <= r_px + 3'd1;
            if (r_px == 3'd7) begin
              r_py <= r_py + 3'd1;
              if (r_py == 3'd7) begin
                if (r_tx == 8'(TX_HI)) begin
                  r_tx <= 8'(TX_LO);
                  r_ty <= r_ty + 8'd1;
                end else begin
                  r_tx <= r_tx + 8'd1;
                end
              end
            end
          end
        end
        S_DRAIN: begin
          if ((r_cnt == 2'd0) && !r_vld_p1) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: read data returns; it is pushed with the sideband captured at issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      r_vld_p1 <= mem_rd;
      if (r_vld_p1) r_wp <= ~r_wp;
      if (w_pop)    r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(r_vld_p1) - 2'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_rd)   r_sb_p1      <= w_sb;
    if (r_vld_p1) r_fifo[r_wp] <= '{data: mem_rdata, sb: r_sb_p1};
  end

  // Output stage: FIFO head, forced to zero when empty so reset/idle values are clean.
  assign w_head     = r_fifo[r_rp];
  assign pix_valid  = (r_cnt != 2'd0);
  assign pix_data   = pix_valid ? w_head.data   : 8'd0;
  assign tile_first = pix_valid & w_head.sb.first;
  assign tile_last  = pix_valid & w_head.sb.last;
  assign tile_edge  = pix_valid & w_head.sb.edg;
  assign tile_idx   = pix_valid ? w_head.sb.idx : 8'd0;

endmodule
